// File: rtl/elevator_car_controller.sv
// Car controller for an 8-floor elevator: latches calls, steps one floor per FLOOR_TICKS, holds the door DOOR_TICKS.
// All outputs registered; a call is seen by dispatch one cycle after its strobe; call strobes are always accepted.
module elevator_car_controller #(
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       call_valid,
    input  logic [2:0] call_floor,
    input  logic       goingUp,
    output logic [7:0] floorsCalled,
    output logic [2:0] currentFloor,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic       arrived
);
    localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CW-1:0] FLOOR_LAST = CW'(FLOOR_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST  = CW'(DOOR_TICKS - 1);
    localparam logic [CW-1:0] TICK_ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t        state_q, state_d;
    logic [7:0]    floors_called_q, floors_called_d;
    logic [2:0]    current_floor_q, current_floor_d;
    logic [CW-1:0] tick_q, tick_d;
    logic          dir_up_q, dir_up_d;
    logic          moving_q, moving_d;
    logic          door_open_q, door_open_d;
    logic          arrived_q, arrived_d;

    logic [7:0]    set_mask, clr_mask, pending, calls_above, calls_below;
    logic [2:0]    next_floor;
    logic          same_floor_call;

    always_comb begin
        same_floor_call = call_valid && (call_floor == current_floor_q);
        set_mask        = '0;
        // A call for the floor whose door is already open only holds the door.
        if (call_valid && !((state_q == DOOR) && same_floor_call))
            set_mask[call_floor] = 1'b1;
        pending     = floors_called_q | set_mask;
        calls_above = floors_called_q & (8'hFE << current_floor_q);
        calls_below = floors_called_q & ((8'h01 << current_floor_q) - 8'h01);
        next_floor  = dir_up_q ? (current_floor_q + 3'd1) : (current_floor_q - 3'd1);

        clr_mask        = '0;
        state_d         = state_q;
        tick_d          = tick_q;
        current_floor_d = current_floor_q;
        dir_up_d        = dir_up_q;
        arrived_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (floors_called_q[current_floor_q]) begin
                    state_d                   = DOOR;
                    tick_d                    = '0;
                    clr_mask[current_floor_q] = 1'b1;
                    arrived_d                 = 1'b1;
                end else if (floors_called_q != 8'h00) begin
                    state_d  = MOVE;
                    tick_d   = '0;
                    // Honour the suggested direction only if something is waiting that way.
                    dir_up_d = goingUp ? (calls_above != 8'h00) : (calls_below == 8'h00);
                end
            end
            MOVE: begin
                if (tick_q == FLOOR_LAST) begin
                    tick_d          = '0;
                    current_floor_d = next_floor;
                    if (pending[next_floor]) begin
                        state_d              = DOOR;
                        clr_mask[next_floor] = 1'b1;
                        arrived_d            = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            DOOR: begin
                if (same_floor_call) begin
                    tick_d = '0;
                end else if (tick_q == DOOR_LAST) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase

        floors_called_d = pending & ~clr_mask;
        moving_d        = (state_d == MOVE);
        door_open_d     = (state_d == DOOR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            floors_called_q <= '0;
            current_floor_q <= '0;
            tick_q          <= '0;
            dir_up_q        <= 1'b1;
            moving_q        <= 1'b0;
            door_open_q     <= 1'b0;
            arrived_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            floors_called_q <= floors_called_d;
            current_floor_q <= current_floor_d;
            tick_q          <= tick_d;
            dir_up_q        <= dir_up_d;
            moving_q        <= moving_d;
            door_open_q     <= door_open_d;
            arrived_q       <= arrived_d;
        end
    end

    assign floorsCalled = floors_called_q;
    assign currentFloor = current_floor_q;
    assign moving       = moving_q;
    assign dir_up       = dir_up_q;
    assign door_open    = door_open_q;
    assign arrived      = arrived_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Bench for elevator_car_controller: directed trips plus random calls, checked against a time-to-go reference model.
module tb_elevator_car_controller;
    localparam int FT = 4;
    localparam int DT = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       call_valid;
    logic [2:0] call_floor;
    logic       goingUp;
    logic [7:0] floorsCalled;
    logic [2:0] currentFloor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       arrived;

    elevator_car_controller #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .clock        (clock),
        .reset        (reset),
        .call_valid   (call_valid),
        .call_floor   (call_floor),
        .goingUp      (goingUp),
        .floorsCalled (floorsCalled),
        .currentFloor (currentFloor),
        .moving       (moving),
        .dir_up       (dir_up),
        .door_open    (door_open),
        .arrived      (arrived)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int prev_floor = 0;

    // Expected {floorsCalled, currentFloor, moving, dir_up, door_open, arrived} per edge, and arrival floors.
    logic [14:0] exp_q[$];
    int          arr_q[$];

    // Reference model: car described by time left to the next floor and time left with the door open.
    bit [7:0] m_calls;
    int       m_floor, m_hop_left, m_door_left, m_heading;
    bit       m_arr;

    function automatic void model_reset();
        m_calls = '0; m_floor = 0; m_hop_left = 0; m_door_left = 0; m_heading = 1; m_arr = 1'b0;
        exp_q.delete();
        arr_q.delete();
    endfunction

    function automatic void model_serve();
        m_calls[m_floor] = 1'b0;
        m_door_left = DT;
        m_arr = 1'b1;
        arr_q.push_back(m_floor);
    endfunction

    function automatic void model_edge(input bit cv, input int cf, input bit gu);
        bit take_call = cv;
        bit any_up = 1'b0;
        bit any_dn = 1'b0;
        m_arr = 1'b0;
        if (m_door_left > 0) begin
            if (cv && cf == m_floor) begin
                m_door_left = DT;
                take_call = 1'b0;
            end else begin
                m_door_left--;
            end
        end else if (m_hop_left > 0) begin
            m_hop_left--;
            if (m_hop_left == 0) begin
                m_floor += m_heading;
                if (m_calls[m_floor] || (cv && cf == m_floor)) begin
                    model_serve();
                    if (cf == m_floor) take_call = 1'b0;
                end else begin
                    m_hop_left = FT;
                end
            end
        end else if (m_calls[m_floor]) begin
            model_serve();
            if (cf == m_floor) take_call = 1'b0;
        end else if (m_calls != 8'h00) begin
            for (int i = 0; i < 8; i++) begin
                if (m_calls[i] && i > m_floor) any_up = 1'b1;
                if (m_calls[i] && i < m_floor) any_dn = 1'b1;
            end
            if (gu) m_heading = any_up ? 1 : -1;
            else    m_heading = any_dn ? -1 : 1;
            m_hop_left = FT;
        end
        if (take_call) m_calls[cf] = 1'b1;
        exp_q.push_back({m_calls, 3'(m_floor), (m_hop_left > 0), (m_heading > 0),
                         (m_door_left > 0), m_arr});
    endfunction

    function automatic bit model_busy();
        return (m_hop_left > 0) || (m_door_left > 0) || (m_calls != 8'h00);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Drive one edge's inputs at the falling edge and advance the model for the coming rising edge.
    task automatic cyc(input bit cv, input int cf, input bit gu);
        @(negedge clock);
        reset      = 1'b0;
        call_valid = cv;
        call_floor = 3'(cf);
        goingUp    = gu;
        model_edge(cv, cf, gu);
    endtask

    task automatic wait_parked(input bit gu);
        for (int i = 0; i < 300 && model_busy(); i++) cyc(1'b0, 0, gu);
        if (model_busy()) chk("park_timeout", 1, 0);
    endtask

    // Mid-cycle reset with no clock edge: outputs must drop at once.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        model_reset();
        prev_floor = 0;
        #1;
        chk({tag, "_floorsCalled"}, int'(floorsCalled), 0);
        chk({tag, "_currentFloor"}, int'(currentFloor), 0);
        chk({tag, "_moving"},       int'(moving), 0);
        chk({tag, "_door_open"},    int'(door_open), 0);
        chk({tag, "_arrived"},      int'(arrived), 0);
        chk({tag, "_dir_up"},       int'(dir_up), 1);
    endtask

    // Monitor: compares every post-edge output against the scoreboard and pops arrivals when the DUT pulses.
    initial begin
        logic [14:0] exp_rec, act_rec;
        int          exp_floor, step;
        forever begin
            @(posedge clock);
            #2;
            if (reset) begin
                prev_floor = 0;
            end else begin
                if (exp_q.size() > 0) begin
                    exp_rec = exp_q.pop_front();
                    act_rec = {floorsCalled, currentFloor, moving, dir_up, door_open, arrived};
                    n_checks++;
                    if (act_rec !== exp_rec) begin
                        n_errors++;
                        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_rec, exp_rec);
                    end
                end
                if (int'(currentFloor) != prev_floor) begin
                    step = int'(currentFloor) - prev_floor;
                    chk("floor_step", (step == 1 || step == -1) ? 1 : 0, 1);
                    prev_floor = int'(currentFloor);
                end
                if (arrived === 1'b1) begin
                    if (arr_q.size() == 0) begin
                        chk("arrival_expected", 0, 1);
                    end else begin
                        exp_floor = arr_q.pop_front();
                        chk("arrival_floor", int'(currentFloor), exp_floor);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "simulation timeout");
    end

    initial begin
        reset = 1'b0; call_valid = 1'b0; call_floor = 3'd0; goingUp = 1'b1;
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("por_floorsCalled", int'(floorsCalled), 0);
        chk("por_moving", int'(moving), 0);

        // Reset mid-cycle while a call is pending and the car has started moving.
        cyc(1'b1, 5, 1'b1);
        cyc(1'b0, 0, 1'b1);
        @(posedge clock); #1;
        chk("t1_moving_before_reset", int'(moving), 1);
        #2 do_reset("t1");

        // Call at the current floor while idle.
        cyc(1'b1, 0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 0, 1'b1);
            @(posedge clock); #1;
            if (k == 1) begin
                chk("t3_door_open", int'(door_open), 1);
                chk("t3_arrived", int'(arrived), 1);
                chk("t3_moving", int'(moving), 0);
                chk("t3_floorsCalled", int'(floorsCalled), 0);
            end
            if (k == 2) chk("t3_arrived_one_cycle", int'(arrived), 0);
        end

        // Upward trip 0 -> 3.
        cyc(1'b1, 3, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 0, 1'b1);
            @(posedge clock); #1;
            case (k)
                1:  begin chk("t2_moving", int'(moving), 1); chk("t2_dir_up", int'(dir_up), 1); end
                5:  chk("t2_floor1", int'(currentFloor), 1);
                9:  chk("t2_floor2", int'(currentFloor), 2);
                13: begin
                    chk("t2_floor3", int'(currentFloor), 3);
                    chk("t2_door_open", int'(door_open), 1);
                    chk("t2_arrived", int'(arrived), 1);
                    chk("t2_floorsCalled", int'(floorsCalled), 0);
                end
                15: chk("t2_door_still_open", int'(door_open), 1);
                16: begin chk("t2_idle_door", int'(door_open), 0); chk("t2_idle_moving", int'(moving), 0); end
                default: ;
            endcase
        end

        // Up to floor 5, then a lone call below with goingUp asserted.
        cyc(1'b1, 5, 1'b1);
        wait_parked(1'b1);
        cyc(1'b1, 2, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            cyc(1'b0, 0, 1'b1);
            @(posedge clock); #1;
            chk("t4_floor_ceiling", (int'(currentFloor) <= 5) ? 1 : 0, 1);
            if (k == 1) chk("t4_dir_up", int'(dir_up), 0);
            if (k == 13) begin
                chk("t4_floor2", int'(currentFloor), 2);
                chk("t4_arrived", int'(arrived), 1);
            end
        end

        // Trip 0 -> 6 with a pickup at 4 and a door extension there.
        cyc(1'b1, 0, 1'b0);
        wait_parked(1'b0);
        cyc(1'b1, 6, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            cyc((k == 11) || (k == 18), 4, 1'b1);
            @(posedge clock); #1;
            if (k >= 17 && k <= 21) chk("t5_bit4_clear", int'(floorsCalled[4]), 0);
            case (k)
                17: begin chk("t5_stop_floor4", int'(currentFloor), 4); chk("t5_arrived4", int'(arrived), 1); end
                20: chk("t5_door_extended", int'(door_open), 1);
                21: chk("t5_door_closed", int'(door_open), 0);
                30: begin chk("t5_floor6", int'(currentFloor), 6); chk("t5_arrived6", int'(arrived), 1); end
                default: ;
            endcase
        end
        wait_parked(1'b1);

        // Head down from 6, add a call behind, reset while passing floor 3.
        cyc(1'b1, 0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            cyc(k == 2, 6, 1'b0);
            @(posedge clock); #1;
        end
        chk("t6_floor3", int'(currentFloor), 3);
        chk("t6_calls", int'(floorsCalled), 8'h41);
        chk("t6_moving", int'(moving), 1);
        #2 do_reset("t6");
        cyc(1'b1, 2, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b0, 0, 1'b1);
            @(posedge clock); #1;
            if (k == 9) begin
                chk("t6_resume_floor2", int'(currentFloor), 2);
                chk("t6_resume_arrived", int'(arrived), 1);
            end
        end
        wait_parked(1'b1);

        // Random traffic.
        for (int n = 0; n < 2500; n++) begin
            cyc($urandom_range(0, 5) == 0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        wait_parked(1'b1);
        @(posedge clock); #3;
        chk("scoreboard_drained", exp_q.size() + arr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
- Sequential counterpart to the combinational direction calculator.
- Latches hall/car calls into the `floorsCalled` vector and owns the `currentFloor` register; both feed the calculator.
- Consumes the calculator's `goingUp` decision and steps the car floor by floor.
- Opens the door at called floors and clears served calls.
- Sits between the call-button inputs and the motor/door actuators of the 8-floor elevator.

Parameters:
FLOOR_TICKS, 4, clock cycles spent travelling between adjacent floors (>=1)
DOOR_TICKS, 3, clock cycles the door stays open per stop (>=1)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
call_valid  input  1  one-cycle strobe: register a call
call_floor  input  3  floor index of the call (0..7)
goingUp  input  1  direction decision from the direction calculator (1 = up)
floorsCalled  output  8  pending-call vector, bit i = floor i requested
currentFloor  output  3  floor the car is at or last passed
moving  output  1  high while in MOVE
dir_up  output  1  latched travel direction (1 = up)
door_open  output  1  high while in DOOR
arrived  output  1  one-cycle pulse on entry to DOOR

Behaviour:
- One clock. Reset is asynchronous and active-high.
- All outputs are registered.
- Reset, any time including mid-move or door-open:
  - state=IDLE; floorsCalled=0; currentFloor=0; dir_up=1.
  - moving=0, door_open=0, arrived=0; tick counter=0.
- Call capture:
  - call_valid at edge sets floorsCalled[call_floor].
  - Exception: no bit is set if state=DOOR and call_floor==currentFloor. The door timer restarts to 0 instead.
  - A set and a clear of different bits on the same edge both take effect.
  - Duplicate calls are idempotent.
- States:
  - IDLE, evaluated every cycle on the registered floorsCalled:
    - If floorsCalled[currentFloor]=1: go to DOOR, clear that bit, pulse arrived.
    - Else if floorsCalled!=0: go to MOVE with counter=0. Set dir_up=goingUp if any call lies in that direction, otherwise the opposite direction.
    - Else stay in IDLE.
    - A new call is visible to IDLE one cycle after its strobe edge.
  - MOVE:
    - The counter increments each cycle.
    - When counter==FLOOR_TICKS-1, currentFloor steps by +1 (dir_up=1) or -1, and the counter resets to 0.
    - If the new floor's bit is set (including a bit set on that same edge): go to DOOR, clear the bit, pulse arrived.
    - Otherwise remain in MOVE with the same dir_up.
    - Direction is never changed mid-travel, and goingUp is ignored in MOVE.
    - The departure rule guarantees a pending call ahead, so currentFloor never wraps below 0 or above 7. The bench asserts this.
  - DOOR:
    - The counter increments each cycle.
    - When counter==DOOR_TICKS-1: go to IDLE with counter=0, door_open=0.
    - Re-dispatch then follows the IDLE rules on the next cycle.
- Output decoding: moving=(state==MOVE); door_open=(state==DOOR); arrived is high only the first cycle of DOOR.
- Timing:
  - Travel between adjacent floors takes exactly FLOOR_TICKS cycles.
  - The door is open exactly DOOR_TICKS cycles, unless it is extended by a same-floor call.
- Tick counter width is sized for max(FLOOR_TICKS, DOOR_TICKS).
- call_floor is always in range (3 bits). There is no error output.

Test Plan:
1. Reset check: assert reset mid-cycle with no clock edge -> all outputs drop immediately. Required values: floorsCalled=0, currentFloor=0, moving=0, door_open=0, arrived=0.
2. Upward trip to floor 3:
   - Stimulus: defaults, call_floor=3 strobed at edge 0, goingUp=1.
   - MOVE from edge 1, dir_up=1.
   - currentFloor=1 at edge 5, 2 at edge 9, 3 at edge 13.
   - At edge 13: door_open=1, arrived pulse, floorsCalled=0.
   - IDLE at edge 16.
3. Call at current floor in IDLE: floor 0 is called -> DOOR one cycle after the strobe, moving stays 0, bit cleared on entry.
4. Conflicting goingUp:
   - Stimulus: car at floor 5, only floor 2 called, goingUp=1.
   - Required: dir_up=0; currentFloor reaches 2 after 3*FLOOR_TICKS cycles; never exceeds 5.
5. Pickup en route and door extension:
   - Stimulus: travelling 0->6; call floor 4 while between 2 and 3.
   - Required: stops at 4 with arrived pulse, then resumes to 6.
   - Stimulus: a floor-4 call during the stop.
   - Required: door stays open a further DOOR_TICKS cycles; bit 4 is never set.
6. Reset mid-move: reset while MOVE at floor 3 with calls 0x41 -> immediate return to IDLE, floor 0, floorsCalled=0. Operation resumes normally after release.
